// File: rtl/structs_pkg.sv
// Shared types for the commit-side JALR resolution controller.
// State encoding plus the target-masking helper.
package structs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TGT,
    ST_RESOLVE,
    ST_FLUSH
  } jalr_ctrl_state_t;

  localparam int XLEN = 32;

  // Architectural JALR target: rs1+imm with bit 0 forced low.
  function automatic logic [XLEN-1:0] jalr_target(
    input logic [XLEN-1:0] addr
  );
    return {addr[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for JALR performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/jalr_resolve_ctrl.sv
// Commit-side JALR resolution FSM: checks the resolved target,
// pops the JALR queue, acks commit and sequences mispredict flushes.
module jalr_resolve_ctrl
  import structs_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rob_head_is_jalr,
  input  logic             ext_flush,
  input  logic             head_ready,
  input  logic [31:0]      jalr_actual_address,
  input  logic [31:0]      jalr_taken_address,
  output logic             jalrq_rd_en,
  output logic             jalrq_clear,
  output logic             commit_ack,
  output logic             commit_stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] jalr_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [3:0] FC_LAST = 4'(FLUSH_CYCLES - 1);

  jalr_ctrl_state_t state, state_n;

  logic [31:0] tgt_q, tgt_n;
  logic [31:0] pred_q, pred_n;
  logic [3:0]  fcnt_q, fcnt_n;

  logic        rd_en_n, clear_n, ack_n;
  logic        rv_n, flush_n;
  logic [31:0] rpc_n;
  logic        inc_jalr, inc_mis;
  logic        cap;
  logic [31:0] tgt_now;

  assign tgt_now = jalr_target(jalr_actual_address);

  // The decision is made at capture so pulses show in the RESOLVE cycle.
  always_comb begin
    state_n  = state;
    tgt_n    = tgt_q;
    pred_n   = pred_q;
    fcnt_n   = fcnt_q;
    rd_en_n  = 1'b0;
    clear_n  = 1'b0;
    ack_n    = 1'b0;
    rv_n     = 1'b0;
    rpc_n    = redirect_pc;
    flush_n  = 1'b0;
    inc_jalr = 1'b0;
    inc_mis  = 1'b0;
    cap      = 1'b0;

    if (ext_flush) begin
      state_n = ST_IDLE;
      clear_n = 1'b1;
      fcnt_n  = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rob_head_is_jalr && head_ready) begin
            cap = 1'b1;
          end else if (rob_head_is_jalr) begin
            state_n = ST_WAIT_TGT;
          end
        end
        ST_WAIT_TGT: begin
          if (!rob_head_is_jalr) begin
            state_n = ST_IDLE;
          end else if (head_ready) begin
            cap = 1'b1;
          end
        end
        ST_RESOLVE: begin
          if ((tgt_q != pred_q) && (fcnt_q != '0)) begin
            state_n = ST_FLUSH;
            fcnt_n  = fcnt_q - 4'd1;
            flush_n = 1'b1;
            clear_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (fcnt_q != '0) begin
            fcnt_n  = fcnt_q - 4'd1;
            flush_n = 1'b1;
            clear_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      endcase

      if (cap) begin
        tgt_n    = tgt_now;
        pred_n   = jalr_taken_address;
        state_n  = ST_RESOLVE;
        rd_en_n  = 1'b1;
        ack_n    = 1'b1;
        inc_jalr = 1'b1;
        fcnt_n   = '0;
        if (tgt_now != jalr_taken_address) begin
          rv_n    = 1'b1;
          rpc_n   = tgt_now;
          flush_n = 1'b1;
          clear_n = 1'b1;
          inc_mis = 1'b1;
          fcnt_n  = FC_LAST;
        end
      end
    end
  end

  // State, captured targets, flush counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      tgt_q          <= '0;
      pred_q         <= '0;
      fcnt_q         <= '0;
      jalrq_rd_en    <= 1'b0;
      jalrq_clear    <= 1'b0;
      commit_ack     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      state          <= state_n;
      tgt_q          <= tgt_n;
      pred_q         <= pred_n;
      fcnt_q         <= fcnt_n;
      jalrq_rd_en    <= rd_en_n;
      jalrq_clear    <= clear_n;
      commit_ack     <= ack_n;
      redirect_valid <= rv_n;
      redirect_pc    <= rpc_n;
      flush          <= flush_n;
    end
  end

  assign commit_stall = (rob_head_is_jalr & ~commit_ack)
                      | (state == ST_FLUSH)
                      | flush;

  sat_counter #(.W(CNT_W)) u_jalr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_jalr),
    .count (jalr_count)
  );

  sat_counter #(.W(CNT_W)) u_mis_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_mis),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_jalr_resolve_ctrl.sv
// Directed bench for jalr_resolve_ctrl.
// Instance a: FLUSH_CYCLES=2, CNT_W=16; instance b: FLUSH_CYCLES=4, CNT_W=4.
module tb_jalr_resolve_ctrl;

  logic clk = 1'b0;
  logic reset, rob, xfl, hr;
  logic [31:0] act, tkn;

  logic a_rd, a_clr, a_ack, a_stall, a_rv, a_fl;
  logic [31:0] a_rpc;
  logic [15:0] a_jc, a_mc;
  logic b_rd, b_clr, b_ack, b_stall, b_rv, b_fl;
  logic [31:0] b_rpc;
  logic [3:0] b_jc, b_mc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jalr_resolve_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .rob_head_is_jalr(rob), .ext_flush(xfl), .head_ready(hr),
    .jalr_actual_address(act), .jalr_taken_address(tkn),
    .jalrq_rd_en(a_rd), .jalrq_clear(a_clr), .commit_ack(a_ack),
    .commit_stall(a_stall), .redirect_valid(a_rv),
    .redirect_pc(a_rpc), .flush(a_fl),
    .jalr_count(a_jc), .mispredict_count(a_mc)
  );

  jalr_resolve_ctrl #(.FLUSH_CYCLES(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .rob_head_is_jalr(rob), .ext_flush(xfl), .head_ready(hr),
    .jalr_actual_address(act), .jalr_taken_address(tkn),
    .jalrq_rd_en(b_rd), .jalrq_clear(b_clr), .commit_ack(b_ack),
    .commit_stall(b_stall), .redirect_valid(b_rv),
    .redirect_pc(b_rpc), .flush(b_fl),
    .jalr_count(b_jc), .mispredict_count(b_mc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rob = 1'b0;
    hr  = 1'b0;
    xfl = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rob = 0; xfl = 0; hr = 0; act = '0; tkn = '0;
    tick(); tick();
    tests++;
    if ({a_rd, a_clr, a_ack, a_rv, a_fl, a_stall} !== 6'b0) begin
      fails++;
      $display("FAIL reset_pulses: got %b want 000000",
               {a_rd, a_clr, a_ack, a_rv, a_fl, a_stall});
    end
    tests++;
    if (a_rpc !== 32'h0) begin
      fails++;
      $display("FAIL reset_rpc: got %h want 0", a_rpc);
    end
    tests++;
    if ({a_jc, a_mc, b_jc, b_mc} !== 40'h0) begin
      fails++;
      $display("FAIL reset_counts: got %h want 0",
               {a_jc, a_mc, b_jc, b_mc});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_correct_predict();
    act = 32'h0000_1005; tkn = 32'h0000_1004;
    hr = 1; rob = 1;
    tick();
    tests++;
    if ({a_ack, a_rd, a_rv, a_fl, a_stall} !== 5'b11000) begin
      fails++;
      $display("FAIL cp_pulses: got %b want 11000",
               {a_ack, a_rd, a_rv, a_fl, a_stall});
    end
    tests++;
    if (a_jc !== 16'd1 || a_mc !== 16'd0) begin
      fails++;
      $display("FAIL cp_counts: got %0d/%0d want 1/0", a_jc, a_mc);
    end
    rob = 0; hr = 0;
    tick();
    tests++;
    if ({a_ack, a_rd} !== 2'b00) begin
      fails++;
      $display("FAIL cp_single_pulse: got %b want 00", {a_ack, a_rd});
    end
  endtask

  task automatic test_mispredict();
    act = 32'h0000_2000; tkn = 32'h0000_1000;
    hr = 1; rob = 1;
    tick();
    tests++;
    if ({a_rv, a_fl, a_clr, a_ack, a_rd, a_stall} !== 6'b111111) begin
      fails++;
      $display("FAIL mp_resolve: got %b want 111111",
               {a_rv, a_fl, a_clr, a_ack, a_rd, a_stall});
    end
    tests++;
    if (a_rpc !== 32'h0000_2000) begin
      fails++;
      $display("FAIL mp_rpc: got %h want 00002000", a_rpc);
    end
    tests++;
    if (a_mc !== 16'd1 || a_jc !== 16'd2) begin
      fails++;
      $display("FAIL mp_counts: got %0d/%0d want 2/1", a_jc, a_mc);
    end
    rob = 0; hr = 0;
    tick();
    tests++;
    if ({a_fl, a_clr, a_stall, a_rv, a_ack, a_rd} !== 6'b111000) begin
      fails++;
      $display("FAIL mp_flush2: got %b want 111000",
               {a_fl, a_clr, a_stall, a_rv, a_ack, a_rd});
    end
    tick();
    tests++;
    if ({a_fl, a_clr, a_stall} !== 3'b000 || a_rpc !== 32'h2000) begin
      fails++;
      $display("FAIL mp_end: got %b rpc %h want 000 rpc 00002000",
               {a_fl, a_clr, a_stall}, a_rpc);
    end
    tests++;
    if (b_fl !== 1'b1) begin
      fails++;
      $display("FAIL mp_b_flush_long: got %b want 1", b_fl);
    end
    idle(4);
  endtask

  task automatic test_late_target();
    int stalls;
    stalls = 0;
    act = 32'h0000_3000; tkn = 32'h0000_3000;
    rob = 1; hr = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) hr = 1;
      #1;
      if (a_stall === 1'b1) stalls++;
      tests++;
      if ({a_ack, a_rd} !== 2'b00) begin
        fails++;
        $display("FAIL lt_early_pop cyc%0d: got %b want 00",
                 i, {a_ack, a_rd});
      end
      tick();
    end
    tests++;
    if (stalls !== 6) begin
      fails++;
      $display("FAIL lt_stall_cycles: got %0d want 6", stalls);
    end
    tests++;
    if ({a_ack, a_rd, a_stall} !== 3'b110) begin
      fails++;
      $display("FAIL lt_ack: got %b want 110", {a_ack, a_rd, a_stall});
    end
    rob = 0; hr = 0;
    tick();
    tests++;
    if (a_rd !== 1'b0 || a_jc !== 16'd3) begin
      fails++;
      $display("FAIL lt_single_pop: got rd %b jc %0d want 0/3",
               a_rd, a_jc);
    end
  endtask

  task automatic test_ext_flush();
    act = 32'h0000_5000; tkn = 32'h0000_4000;
    rob = 1; hr = 0;
    tick();
    xfl = 1;
    tick();
    tests++;
    if ({a_clr, a_fl, a_rd, a_ack, a_rv} !== 5'b10000) begin
      fails++;
      $display("FAIL xf_wait: got %b want 10000",
               {a_clr, a_fl, a_rd, a_ack, a_rv});
    end
    xfl = 0; rob = 0;
    tick();
    tests++;
    if (a_clr !== 1'b0) begin
      fails++;
      $display("FAIL xf_wait_clr_len: got %b want 0", a_clr);
    end
    rob = 1; hr = 1; xfl = 1;
    tick();
    tests++;
    if ({a_clr, a_fl, a_rd, a_ack, a_rv} !== 5'b10000) begin
      fails++;
      $display("FAIL xf_mispredict: got %b want 10000",
               {a_clr, a_fl, a_rd, a_ack, a_rv});
    end
    tests++;
    if (a_jc !== 16'd3 || a_mc !== 16'd1) begin
      fails++;
      $display("FAIL xf_counts: got %0d/%0d want 3/1", a_jc, a_mc);
    end
    xfl = 0; rob = 0; hr = 0;
    tick();
    tests++;
    if ({a_clr, a_rv, a_fl} !== 3'b000) begin
      fails++;
      $display("FAIL xf_after: got %b want 000", {a_clr, a_rv, a_fl});
    end
  endtask

  task automatic test_bit0_pred();
    act = 32'h0000_6001; tkn = 32'h0000_6001;
    rob = 1; hr = 1;
    tick();
    tests++;
    if ({a_rv, a_ack} !== 2'b11 || a_rpc !== 32'h0000_6000) begin
      fails++;
      $display("FAIL b0_mispredict: got %b rpc %h want 11 rpc 00006000",
               {a_rv, a_ack}, a_rpc);
    end
    tests++;
    if (a_mc !== 16'd2) begin
      fails++;
      $display("FAIL b0_count: got %0d want 2", a_mc);
    end
    idle(6);
  endtask

  task automatic test_back_to_back_saturation();
    int n;
    for (int i = 0; i < 20; i++) begin
      act = 32'h0000_8000 + 32'(i * 16);
      tkn = 32'h0;
      rob = 1; hr = 1;
      tick();
      tests++;
      if ({b_ack, b_rv, a_ack, a_rv} !== 4'b1111) begin
        fails++;
        $display("FAIL sat_resolve %0d: got %b want 1111",
                 i, {b_ack, b_rv, a_ack, a_rv});
      end
      if (i == 11) begin
        tests++;
        if (b_mc !== 4'd14) begin
          fails++;
          $display("FAIL sat_pre: got %0d want 14", b_mc);
        end
      end
      rob = 0; hr = 0;
      n = 0;
      while ((b_stall || a_stall) && n < 20) begin
        tick();
        n++;
      end
      tests++;
      if (n >= 20) begin
        fails++;
        $display("FAIL sat_timeout %0d: stall still %b want 0",
                 i, b_stall);
      end
    end
    tests++;
    if (b_mc !== 4'hF || b_jc !== 4'hF) begin
      fails++;
      $display("FAIL sat_hold: got %h/%h want F/F", b_jc, b_mc);
    end
    tests++;
    if (a_mc !== 16'd22 || a_jc !== 16'd24) begin
      fails++;
      $display("FAIL sat_wide: got %0d/%0d want 24/22", a_jc, a_mc);
    end
  endtask

  task automatic test_reset_mid_flush();
    act = 32'h0000_9000; tkn = 32'h0;
    rob = 1; hr = 1;
    tick();
    rob = 0; hr = 0;
    tick();
    tests++;
    if ({b_fl, b_clr, b_stall} !== 3'b111) begin
      fails++;
      $display("FAIL rmf_in_flush: got %b want 111",
               {b_fl, b_clr, b_stall});
    end
    reset = 1;
    tick();
    tests++;
    if ({b_fl, b_clr, b_rv, b_rd, b_ack, b_stall} !== 6'b0) begin
      fails++;
      $display("FAIL rmf_outs: got %b want 000000",
               {b_fl, b_clr, b_rv, b_rd, b_ack, b_stall});
    end
    tests++;
    if (b_rpc !== 32'h0 || b_jc !== 4'h0 || b_mc !== 4'h0) begin
      fails++;
      $display("FAIL rmf_regs: got rpc %h cnt %h/%h want 0",
               b_rpc, b_jc, b_mc);
    end
    reset = 0;
    act = 32'h0000_A000; tkn = 32'h0000_A000;
    rob = 1; hr = 1;
    tick();
    tests++;
    if ({b_ack, b_rv} !== 2'b10 || b_jc !== 4'd1) begin
      fails++;
      $display("FAIL rmf_idle: got %b jc %0d want 10 jc 1",
               {b_ack, b_rv}, b_jc);
    end
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_correct_predict();
    test_mispredict();
    test_late_target();
    test_ext_flush();
    test_bit0_pred();
    test_back_to_back_saturation();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
